// File: rtl/sblk_act_feeder.sv
// Activation feeder: demultiplexes one tagged activation stream into per-row FIFOs
// and drives each row's activation input under that row's request flow control.
module sblk_act_feeder #(
    parameter int unsigned N_ROW      = 3,
    parameter int unsigned WID_ACT    = 16,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned WID_ROW    = (N_ROW > 1) ? $clog2(N_ROW) : 1,
    parameter int unsigned WID_CNT    = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                          clk_l,
    input  logic                          rst_n,
    input  logic                          flush,
    input  logic [2*WID_ACT-1:0]          in_data,
    input  logic [WID_ROW-1:0]            in_row,
    input  logic                          in_vld,
    output logic                          in_rdy,
    output logic [2*WID_ACT*N_ROW-1:0]    act_data_in,
    output logic [N_ROW-1:0]              act_data_in_vld,
    input  logic [N_ROW-1:0]              act_data_in_req,
    output logic [N_ROW-1:0]              fifo_empty,
    output logic                          row_err
);

    localparam int unsigned WID_WORD = 2 * WID_ACT;
    localparam int unsigned WID_PTR  = $clog2(FIFO_DEPTH);

    logic [WID_WORD-1:0] mem    [N_ROW][FIFO_DEPTH];
    logic [WID_PTR-1:0]  wr_ptr [N_ROW];
    logic [WID_PTR-1:0]  rd_ptr [N_ROW];
    logic [WID_CNT-1:0]  cnt    [N_ROW];

    logic             row_bad;
    logic             sel_full;
    logic             accept;
    logic [N_ROW-1:0] push;
    logic [N_ROW-1:0] pop;

    // Handshake and per-row push/pop decode; in_rdy looks only at registered counts.
    always_comb begin
        row_bad  = 32'(in_row) >= N_ROW;
        sel_full = 1'b0;
        for (int unsigned r = 0; r < N_ROW; r++) begin
            if (!row_bad && 32'(in_row) == r && cnt[r] == WID_CNT'(FIFO_DEPTH)) begin
                sel_full = 1'b1;
            end
        end
        in_rdy = !flush && !sel_full;
        accept = in_vld && in_rdy;
        for (int unsigned r = 0; r < N_ROW; r++) begin
            push[r]       = accept && 32'(in_row) == r;
            pop[r]        = act_data_in_req[r] && cnt[r] != '0 && !flush;
            fifo_empty[r] = cnt[r] == '0;
        end
    end

    // Word storage needs no reset: a slot is only read after it has been written.
    always_ff @(posedge clk_l) begin
        for (int unsigned r = 0; r < N_ROW; r++) begin
            if (push[r]) begin
                mem[r][wr_ptr[r]] <= in_data;
            end
        end
    end

    // Pointers, occupancy, output registers and the sticky tag error.
    always_ff @(posedge clk_l or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned r = 0; r < N_ROW; r++) begin
                wr_ptr[r] <= '0;
                rd_ptr[r] <= '0;
                cnt[r]    <= '0;
            end
            act_data_in     <= '0;
            act_data_in_vld <= '0;
            row_err         <= 1'b0;
        end else if (flush) begin
            // Output data is intentionally kept; only state and strobes clear.
            for (int unsigned r = 0; r < N_ROW; r++) begin
                wr_ptr[r] <= '0;
                rd_ptr[r] <= '0;
                cnt[r]    <= '0;
            end
            act_data_in_vld <= '0;
            row_err         <= 1'b0;
        end else begin
            for (int unsigned r = 0; r < N_ROW; r++) begin
                if (push[r]) begin
                    wr_ptr[r] <= wr_ptr[r] + WID_PTR'(1);
                end
                if (pop[r]) begin
                    rd_ptr[r] <= rd_ptr[r] + WID_PTR'(1);
                    act_data_in[r*WID_WORD +: WID_WORD] <= mem[r][rd_ptr[r]];
                end
                act_data_in_vld[r] <= pop[r];
                if (push[r] && !pop[r]) begin
                    cnt[r] <= cnt[r] + WID_CNT'(1);
                end else if (pop[r] && !push[r]) begin
                    cnt[r] <= cnt[r] - WID_CNT'(1);
                end
            end
            if (accept && row_bad) begin
                row_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sblk_act_feeder.sv
// Directed bench for sblk_act_feeder: latency, backpressure, streaming, bad tags,
// flush and asynchronous reset, with hand-computed expectations.
module tb_sblk_act_feeder;

    logic        clk_l = 1'b0;
    logic        rst_n;
    logic        flush;
    logic [31:0] in_data;
    logic [1:0]  in_row;
    logic        in_vld;
    logic        in_rdy;
    logic [95:0] act_data_in;
    logic [2:0]  act_data_in_vld;
    logic [2:0]  act_data_in_req;
    logic [2:0]  fifo_empty;
    logic        row_err;

    int n_total = 0;
    int n_pass  = 0;

    sblk_act_feeder dut (
        .clk_l           (clk_l),
        .rst_n           (rst_n),
        .flush           (flush),
        .in_data         (in_data),
        .in_row          (in_row),
        .in_vld          (in_vld),
        .in_rdy          (in_rdy),
        .act_data_in     (act_data_in),
        .act_data_in_vld (act_data_in_vld),
        .act_data_in_req (act_data_in_req),
        .fifo_empty      (fifo_empty),
        .row_err         (row_err)
    );

    always #5 clk_l = ~clk_l;

    task automatic tick();
        @(posedge clk_l);
        #1;
    endtask

    task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [31:0] word_of(input logic [95:0] bus, input int r);
        return bus[r*32 +: 32];
    endfunction

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_data = '0; in_row = '0; in_vld = 1'b0;
        act_data_in_req = '0;
        #12;
        check("rst_empty", 96'(fifo_empty), 96'(3'b111));
        check("rst_err",   96'(row_err), 96'(1'b0));
        check("rst_vld",   96'(act_data_in_vld), 96'(3'b000));
        check("rst_data",  act_data_in, 96'(0));
        check("rst_rdy",   96'(in_rdy), 96'(1'b1));
        #10 rst_n = 1'b1;
        tick();

        // Single word to row 1: strobe two edges after the handshake.
        in_vld = 1'b1; in_row = 2'd1; in_data = 32'h0001_0002; act_data_in_req = 3'b010;
        tick();
        in_vld = 1'b0;
        check("lat_vld_e0",   96'(act_data_in_vld), 96'(3'b000));
        check("lat_empty_e0", 96'(fifo_empty), 96'(3'b101));
        tick();
        check("lat_vld_e1",   96'(act_data_in_vld), 96'(3'b010));
        check("lat_data_e1",  96'(word_of(act_data_in, 1)), 96'(32'h0001_0002));
        check("lat_empty_e1", 96'(fifo_empty), 96'(3'b111));
        tick();
        check("lat_vld_e2",   96'(act_data_in_vld), 96'(3'b000));
        act_data_in_req = 3'b000;

        // Fill row 0, then confirm row 0 is blocked while row 2 is not.
        for (int i = 0; i < 4; i++) begin
            in_vld = 1'b1; in_row = 2'd0; in_data = 32'hA000_0000 + 32'(i);
            #1 check("fill_rdy", 96'(in_rdy), 96'(1'b1));
            tick();
        end
        check("full_rdy_row0", 96'(in_rdy), 96'(1'b0));
        tick();
        check("full_no_strobe", 96'(act_data_in_vld), 96'(3'b000));
        in_row = 2'd2; in_data = 32'hB000_0002;
        #1 check("full_rdy_row2", 96'(in_rdy), 96'(1'b1));
        tick();
        check("row2_accepted", 96'(fifo_empty), 96'(3'b010));
        in_vld = 1'b0; in_row = 2'd0; act_data_in_req = 3'b001;
        #1 check("drain_rdy_pre", 96'(in_rdy), 96'(1'b0));
        for (int i = 0; i < 4; i++) begin
            tick();
            check("drain_vld",  96'(act_data_in_vld), 96'(3'b001));
            check("drain_data", 96'(word_of(act_data_in, 0)), 96'(32'hA000_0000 + 32'(i)));
            if (i == 0) check("drain_rdy_post", 96'(in_rdy), 96'(1'b1));
        end
        act_data_in_req = 3'b000;
        tick();
        check("drain_done_vld", 96'(act_data_in_vld), 96'(3'b000));

        // Streaming on row 2: the leftover word first, then the stream in order.
        act_data_in_req = 3'b100; in_vld = 1'b1; in_row = 2'd2;
        for (int k = 0; k < 6; k++) begin
            in_data = 32'hC000_0000 + 32'(k);
            tick();
            check("stream_vld",  96'(act_data_in_vld), 96'(3'b100));
            check("stream_data", 96'(word_of(act_data_in, 2)),
                  96'((k == 0) ? 32'hB000_0002 : 32'hC000_0000 + 32'(k - 1)));
            check("stream_occ",  96'(fifo_empty), 96'(3'b011));
        end
        in_vld = 1'b0; act_data_in_req = 3'b000;
        for (int k = 0; k < 2; k++) begin
            tick();
            check("stop_vld", 96'(act_data_in_vld), 96'(3'b000));
        end
        check("stop_held", 96'(fifo_empty), 96'(3'b011));
        act_data_in_req = 3'b100;
        tick();
        act_data_in_req = 3'b000;
        check("tail_data",  96'(word_of(act_data_in, 2)), 96'(32'hC000_0005));
        check("tail_empty", 96'(fifo_empty), 96'(3'b111));

        // Out-of-range tag: accepted, dropped, sticky error until flush.
        in_vld = 1'b1; in_row = 2'd3; in_data = 32'hDEAD_BEEF; act_data_in_req = 3'b111;
        #1 check("bad_rdy", 96'(in_rdy), 96'(1'b1));
        tick();
        in_vld = 1'b0;
        check("bad_err",   96'(row_err), 96'(1'b1));
        check("bad_empty", 96'(fifo_empty), 96'(3'b111));
        tick();
        check("bad_no_strobe", 96'(act_data_in_vld), 96'(3'b000));
        check("bad_err_hold",  96'(row_err), 96'(1'b1));
        act_data_in_req = 3'b000; flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_err", 96'(row_err), 96'(1'b0));

        // Flush with two words in rows 0 and 1, a pending push and requests high.
        for (int i = 0; i < 4; i++) begin
            in_vld = 1'b1; in_row = 2'(i / 2); in_data = 32'hD000_0000 + 32'(i);
            tick();
        end
        check("pre_flush_empty", 96'(fifo_empty), 96'(3'b100));
        in_row = 2'd0; in_data = 32'hEEEE_EEEE; act_data_in_req = 3'b011; flush = 1'b1;
        #1 check("flush_rdy", 96'(in_rdy), 96'(1'b0));
        tick();
        flush = 1'b0; in_vld = 1'b0;
        check("flush_vld",   96'(act_data_in_vld), 96'(3'b000));
        check("flush_empty", 96'(fifo_empty), 96'(3'b111));
        check("flush_keep0", 96'(word_of(act_data_in, 0)), 96'(32'hA000_0003));
        check("flush_keep1", 96'(word_of(act_data_in, 1)), 96'(32'h0001_0002));
        tick();
        check("post_flush_vld", 96'(act_data_in_vld), 96'(3'b000));

        // Asynchronous reset in the middle of a row-1 burst.
        act_data_in_req = 3'b010;
        for (int i = 0; i < 3; i++) begin
            in_vld = 1'b1; in_row = 2'd1; in_data = 32'hF000_0000 + 32'(i);
            tick();
        end
        in_vld = 1'b0;
        check("burst_vld",  96'(act_data_in_vld), 96'(3'b010));
        check("burst_data", 96'(word_of(act_data_in, 1)), 96'(32'hF000_0001));
        #2 rst_n = 1'b0;
        #1;
        check("arst_vld",   96'(act_data_in_vld), 96'(3'b000));
        check("arst_data",  act_data_in, 96'(0));
        check("arst_empty", 96'(fifo_empty), 96'(3'b111));
        tick();
        #2 rst_n = 1'b1;
        tick();
        check("post_rst_vld",   96'(act_data_in_vld), 96'(3'b000));
        check("post_rst_empty", 96'(fifo_empty), 96'(3'b111));
        act_data_in_req = 3'b000;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
